// File: rtl/regfile_dump.sv
// Walks the register-file read port and streams (index, value) beats to a debug sink.
// Latency: first beat valid two edges after start is accepted; one beat per 2 cycles at best.
// Backpressure: beat held stable in SEND until i_ready; abort or reset drops it immediately.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int SKIP_X0  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // x0 is hardwired zero, so it can be left out of the dump
  localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;

  // Next-state and datapath decode; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          idx_d   = FIRST_IDX;
          state_d = READ;
        end
      end
      READ: begin
        // Capture the register in its own cycle; beat stays frozen through SEND
        addr_d  = idx_q;
        data_d  = i_rf_data;
        last_d  = (idx_q == LAST_IDX);
        state_d = SEND;
      end
      SEND: begin
        if (i_ready) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (i_abort) begin
      state_d = IDLE;
      idx_d   = '0;
      last_d  = 1'b0;
    end
  end

  // State and beat registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Outputs decoded from state and registers only; no path from i_ready to o_valid
  assign o_rf_addr = idx_q;
  assign o_valid   = (state_q == SEND);
  assign o_addr    = addr_q;
  assign o_data    = data_q;
  assign o_last    = last_q & (state_q == SEND);
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: two instances (x0 skipped / x0 included) against a preloaded regfile model.
// Expected beats are queued at stimulus time and popped by per-instance monitors on each handshake.
// Ready is driven high, pseudo-random, or stalled at a chosen index to exercise backpressure.
module tb_regfile_dump;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        start_a, abort_a, ready_a;
  logic        start_b, abort_b, ready_b;
  logic [4:0]  rf_addr_a, rf_addr_b, o_addr_a, o_addr_b;
  logic [31:0] rf_data_a, rf_data_b, o_data_a, o_data_b;
  logic        o_valid_a, o_last_a, o_busy_a, o_done_a;
  logic        o_valid_b, o_last_b, o_busy_b, o_done_b;

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;
  int ready_mode = 0;   // 0 high, 1 random 30%, 2 stall on index 7
  int done_cnt_a = 0, done_cnt_b = 0, done_cyc_a = 0;
  beat_t qa[$];
  beat_t qb[$];

  // regfile model: x[i] = 0x1000_0000 + i
  assign rf_data_a = 32'h1000_0000 + {27'd0, rf_addr_a};
  assign rf_data_b = 32'h1000_0000 + {27'd0, rf_addr_b};

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_abort(abort_a),
    .o_rf_addr(rf_addr_a), .i_rf_data(rf_data_a), .o_valid(o_valid_a), .i_ready(ready_a),
    .o_addr(o_addr_a), .o_data(o_data_a), .o_last(o_last_a), .o_busy(o_busy_a), .o_done(o_done_a)
  );

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_abort(abort_b),
    .o_rf_addr(rf_addr_b), .i_rf_data(rf_data_b), .o_valid(o_valid_b), .i_ready(ready_b),
    .o_addr(o_addr_b), .o_data(o_data_b), .o_last(o_last_b), .o_busy(o_busy_b), .o_done(o_done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks = nchecks + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input int i);
    beat_t e;
    e.addr = 5'(i);
    e.data = 32'h1000_0000 + 32'(i);
    e.last = (i == 31);
    return e;
  endfunction

  task automatic push_a(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) qa.push_back(mk(i));
  endtask

  // Ready driver for instance A, updated just after each rising edge
  initial begin
    ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       ready_a = ($urandom_range(0, 9) < 3);
        2:       ready_a = !(o_valid_a && (o_addr_a == 5'd7));
        default: ready_a = 1'b1;
      endcase
    end
  end

  // Monitor A: scoreboard pop on handshake, beat stability under stall, done counting
  initial begin
    logic        stall_pend;
    logic [36:0] held;
    beat_t       e;
    stall_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 1'b0;
      end else begin
        if (o_done_a) begin
          done_cnt_a = done_cnt_a + 1;
          done_cyc_a = cyc;
        end
        if (stall_pend && o_valid_a)
          check("beat_hold_a", {27'd0, o_addr_a, o_data_a}, {27'd0, held});
        stall_pend = o_valid_a && !ready_a;
        held = {o_addr_a, o_data_a};
        if (o_valid_a && ready_a) begin
          check("beat_expected_a", 64'(qa.size() != 0), 64'd1);
          if (qa.size() != 0) begin
            e = qa.pop_front();
            check("beat_a", {26'd0, o_addr_a, o_data_a, o_last_a}, {26'd0, e.addr, e.data, e.last});
          end
        end
      end
    end
  end

  // Monitor B
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_done_b) done_cnt_b = done_cnt_b + 1;
        if (o_valid_b && ready_b) begin
          check("beat_expected_b", 64'(qb.size() != 0), 64'd1);
          if (qb.size() != 0) begin
            e = qb.pop_front();
            check("beat_b", {26'd0, o_addr_b, o_data_b, o_last_b}, {26'd0, e.addr, e.data, e.last});
          end
        end
      end
    end
  end

  // Pulse start on A for one edge; returns the cycle number of the sampling edge
  task automatic start_pulse_a(output int s_cyc);
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done_a(input string name, input int budget);
    int base;
    bit seen;
    base = done_cnt_a;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt_a != base) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_stall7_a(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (o_valid_a && o_addr_a == 5'd7) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic check_zero_a(input string name);
    check(name, {26'd0, rf_addr_a, o_valid_a, o_addr_a, o_data_a[19:0], o_last_a, o_busy_a, o_done_a},
          64'd0);
    check({name, "_data"}, {32'd0, o_data_a}, 64'd0);
  endtask

  initial begin
    int s_cyc, base, vcount;
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
    #2;
    check_zero_a("reset_outputs");
    check("reset_b", {57'd0, o_valid_b, o_busy_b, o_done_b, o_addr_b[3:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full dump, ready held high: 31 beats, done 62 edges after the start edge
    ready_mode = 0;
    push_a(1, 31);
    base = done_cnt_a;
    start_pulse_a(s_cyc);
    @(negedge clk);
    check("busy_after_start", {62'd0, o_busy_a, o_valid_a}, 64'd2);
    @(negedge clk);
    check("valid_second_cycle", 64'(o_valid_a), 64'd1);
    wait_done_a("done_timeout_full", 200);
    check("done_cycle_full", 64'(done_cyc_a - s_cyc), 64'd62);
    @(negedge clk);
    check("busy_after_done", 64'(o_busy_a), 64'd0);
    check("done_once_full", 64'(done_cnt_a - base), 64'd1);
    check("queue_empty_full", 64'(qa.size()), 64'd0);

    // Random 30% ready: same sequence, beats held stable while stalled
    ready_mode = 1;
    push_a(1, 31);
    base = done_cnt_a;
    start_pulse_a(s_cyc);
    wait_done_a("done_timeout_rand", 2000);
    repeat (3) @(negedge clk);
    check("done_once_rand", 64'(done_cnt_a - base), 64'd1);
    check("queue_empty_rand", 64'(qa.size()), 64'd0);
    ready_mode = 0;

    // Instance with x0 included: 32 beats starting at index 0
    for (int i = 0; i <= 31; i++) qb.push_back(mk(i));
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int i = 0; i < 200 && done_cnt_b == 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_b", 64'(done_cnt_b), 64'd1);
    check("queue_empty_b", 64'(qb.size()), 64'd0);

    // Abort while stalled in SEND at index 7
    ready_mode = 2;
    push_a(1, 6);
    base = done_cnt_a;
    start_pulse_a(s_cyc);
    wait_stall7_a("stall7_timeout_abort");
    @(posedge clk);
    #1 abort_a = 1'b1;
    @(posedge clk);
    #1 abort_a = 1'b0;
    @(negedge clk);
    check("abort_outputs", {61'd0, o_valid_a, o_busy_a, o_last_a}, 64'd0);
    check("abort_rf_addr", 64'(rf_addr_a), 64'd0);
    repeat (4) @(negedge clk);
    check("abort_no_done", 64'(done_cnt_a - base), 64'd0);
    check("abort_queue", 64'(qa.size()), 64'd0);

    // Restart after abort, with repeated start pulses during the dump
    ready_mode = 0;
    push_a(1, 31);
    base = done_cnt_a;
    start_pulse_a(s_cyc);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1 start_a = o_busy_a && (i % 5 == 2);
    end
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    check("restart_done_once", 64'(done_cnt_a - base), 64'd1);
    check("restart_queue", 64'(qa.size()), 64'd0);

    // Start together with abort in IDLE: nothing happens
    base = done_cnt_a;
    @(posedge clk);
    #1 begin start_a = 1'b1; abort_a = 1'b1; end
    @(posedge clk);
    #1 begin start_a = 1'b0; abort_a = 1'b0; end
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_valid_a || o_busy_a) vcount = vcount + 1;
    end
    check("start_abort_idle", 64'(vcount), 64'd0);
    check("start_abort_no_done", 64'(done_cnt_a - base), 64'd0);

    // Reset mid-dump, off the clock edge
    ready_mode = 2;
    push_a(1, 6);
    start_pulse_a(s_cyc);
    wait_stall7_a("stall7_timeout_reset");
    #2 rst = 1'b1;
    #1;
    check_zero_a("reset_mid_dump");
    check("reset_queue", 64'(qa.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    push_a(1, 31);
    base = done_cnt_a;
    start_pulse_a(s_cyc);
    wait_done_a("done_timeout_post_reset", 200);
    check("post_reset_done_cycle", 64'(done_cyc_a - s_cyc), 64'd62);
    repeat (2) @(negedge clk);
    check("post_reset_done_once", 64'(done_cnt_a - base), 64'd1);
    check("post_reset_queue", 64'(qa.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
